ctl_segment_latch: RTL and testbench



---
 rtl/ctl_segment_latch.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_ctl_segment_latch.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_segment_latch.sv
// ctl_segment_latch: controller register bank between the CPU-side BRAM port
// and the modulation, STM and silencer engines. CPU writes land in shadow
// registers; a control-flag write raises UPDATE_REQ for a subsystem, and the
// consumer's UPDATE_ACK copies that subsystem's shadow into its active
// outputs in one cycle.
// Optional build macro: AUTD3_CTL_READBACK_EN -- when defined, DOUT also
// returns shadow contents of every mapped segment/silencer/read-segment address.
module ctl_segment_latch #(
  parameter int NUM_SEGMENTS = 2,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         WE,
  input  logic [7:0]                   ADDR,
  input  logic [DATA_WIDTH-1:0]        DIN,
  output logic [DATA_WIDTH-1:0]        DOUT,
  output logic [2:0]                   UPDATE_REQ,
  input  logic [2:0]                   UPDATE_ACK,
  output logic [16*NUM_SEGMENTS-1:0]   MOD_CYCLE,
  output logic [32*NUM_SEGMENTS-1:0]   MOD_FREQ_DIV,
  output logic [32*NUM_SEGMENTS-1:0]   MOD_REP,
  output logic [1:0]                   MOD_RD_SEGMENT,
  output logic [16*NUM_SEGMENTS-1:0]   STM_CYCLE,
  output logic [32*NUM_SEGMENTS-1:0]   STM_FREQ_DIV,
  output logic [32*NUM_SEGMENTS-1:0]   STM_REP,
  output logic [NUM_SEGMENTS-1:0]      STM_MODE,
  output logic [32*NUM_SEGMENTS-1:0]   STM_SOUND_SPEED,
  output logic [1:0]                   STM_RD_SEGMENT,
  output logic                         SILENCER_MODE,
  output logic [15:0]                  SILENCER_UR_INT,
  output logic [15:0]                  SILENCER_UR_PHASE,
  output logic [15:0]                  SILENCER_CS_INT,
  output logic [15:0]                  SILENCER_CS_PHASE
);

  localparam logic [15:0] VERSION_MAJOR = 16'h00A2;
  localparam logic [15:0] VERSION_MINOR = 16'h0001;

  localparam int SUB_MOD = 0;
  localparam int SUB_STM = 1;
  localparam int SUB_SIL = 2;

  typedef enum logic {IDLE, PENDING} req_state_e;

  typedef struct packed {
    logic [15:0] cycle;
    logic [31:0] freq_div;
    logic [31:0] rep;
  } mod_seg_t;

  typedef struct packed {
    logic [15:0] cycle;
    logic [31:0] freq_div;
    logic [31:0] rep;
    logic        mode;
    logic [31:0] sound_speed;
  } stm_seg_t;

  typedef struct packed {
    logic        mode;
    logic [15:0] ur_int;
    logic [15:0] ur_phase;
    logic [15:0] cs_int;
    logic [15:0] cs_phase;
  } sil_t;

  localparam sil_t SIL_RESET = '{mode: 1'b0, ur_int: 16'd256, ur_phase: 16'd256,
                                 cs_int: 16'd10, cs_phase: 16'd40};

  mod_seg_t   mod_sh_q  [NUM_SEGMENTS];
  mod_seg_t   mod_sh_d  [NUM_SEGMENTS];
  mod_seg_t   mod_act_q [NUM_SEGMENTS];
  mod_seg_t   mod_act_d [NUM_SEGMENTS];
  stm_seg_t   stm_sh_q  [NUM_SEGMENTS];
  stm_seg_t   stm_sh_d  [NUM_SEGMENTS];
  stm_seg_t   stm_act_q [NUM_SEGMENTS];
  stm_seg_t   stm_act_d [NUM_SEGMENTS];
  sil_t       sil_sh_q, sil_sh_d, sil_act_q, sil_act_d;
  logic [1:0] mod_rd_sh_q, mod_rd_sh_d, mod_rd_act_q, mod_rd_act_d;
  logic [1:0] stm_rd_sh_q, stm_rd_sh_d, stm_rd_act_q, stm_rd_act_d;
  req_state_e state_q [3];
  req_state_e state_d [3];
  logic [2:0] flag_set;
  logic [2:0] commit;
  logic [15:0] rdata_d;

  // Shadow write decode: every mapped CPU write updates the shadow bank.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    mod_sh_d    = mod_sh_q;
    stm_sh_d    = stm_sh_q;
    sil_sh_d    = sil_sh_q;
    mod_rd_sh_d = mod_rd_sh_q;
    stm_rd_sh_d = stm_rd_sh_q;
    flag_set    = 3'b000;
    if (WE) begin
      case (ADDR)
        8'h00: flag_set          = DIN[2:0];
        8'h21: mod_rd_sh_d       = DIN[1:0];
        8'h52: stm_rd_sh_d       = DIN[1:0];
        8'h40: sil_sh_d.mode     = DIN[0];
        8'h41: sil_sh_d.ur_int   = DIN;
        8'h42: sil_sh_d.ur_phase = DIN;
        8'h43: sil_sh_d.cs_int   = DIN;
        8'h44: sil_sh_d.cs_phase = DIN;
        default: ;
      endcase
      for (int s = 0; s < NUM_SEGMENTS; s++) begin
        if (ADDR[7:5] == 3'b100 && ADDR[4:3] == 2'(s)) begin
          case (ADDR[2:0])
            3'd0: mod_sh_d[s].cycle          = DIN;
            3'd1: mod_sh_d[s].freq_div[15:0]  = DIN;
            3'd2: mod_sh_d[s].freq_div[31:16] = DIN;
            3'd3: mod_sh_d[s].rep[15:0]       = DIN;
            3'd4: mod_sh_d[s].rep[31:16]      = DIN;
            default: ;
          endcase
        end
        if (ADDR[7:5] == 3'b101 && ADDR[4:3] == 2'(s)) begin
          case (ADDR[2:0])
            3'd0: stm_sh_d[s].cycle              = DIN;
            3'd1: stm_sh_d[s].freq_div[15:0]     = DIN;
            3'd2: stm_sh_d[s].freq_div[31:16]    = DIN;
            3'd3: stm_sh_d[s].rep[15:0]          = DIN;
            3'd4: stm_sh_d[s].rep[31:16]         = DIN;
            3'd5: stm_sh_d[s].mode               = DIN[0];
            3'd6: stm_sh_d[s].sound_speed[15:0]  = DIN;
            default: stm_sh_d[s].sound_speed[31:16] = DIN;
          endcase
        end
      end
    end
  end

  // Per-subsystem request FSM; a new flag write wins over the ack so a
  // coincident request stays pending after the commit.
  always_comb begin
    commit     = 3'b000;
    UPDATE_REQ = 3'b000;
    for (int k = 0; k < 3; k++) begin
      state_d[k]    = state_q[k];
      UPDATE_REQ[k] = (state_q[k] == PENDING);
      commit[k]     = (state_q[k] == PENDING) && UPDATE_ACK[k];
      if (flag_set[k]) begin
        state_d[k] = PENDING;
      end else if (commit[k]) begin
        state_d[k] = IDLE;
      end
    end
  end

  // Commit: load actives from the next shadow so an ack-cycle write is included.
  always_comb begin
    mod_act_d    = mod_act_q;
    stm_act_d    = stm_act_q;
    sil_act_d    = sil_act_q;
    mod_rd_act_d = mod_rd_act_q;
    stm_rd_act_d = stm_rd_act_q;
    if (commit[SUB_MOD]) begin
      mod_act_d    = mod_sh_d;
      mod_rd_act_d = mod_rd_sh_d;
    end
    if (commit[SUB_STM]) begin
      stm_act_d    = stm_sh_d;
      stm_rd_act_d = stm_rd_sh_d;
    end
    if (commit[SUB_SIL]) begin
      sil_act_d = sil_sh_d;
    end
  end

  // Read mux: status and version always, shadow contents when readback is built in.
  always_comb begin
    rdata_d = 16'h0000;
    case (ADDR)
      8'h01: rdata_d = {13'b0, UPDATE_REQ};
      8'h30: rdata_d = VERSION_MAJOR;
      8'h31: rdata_d = VERSION_MINOR;
`ifdef AUTD3_CTL_READBACK_EN
      8'h21: rdata_d = {14'b0, mod_rd_sh_q};
      8'h52: rdata_d = {14'b0, stm_rd_sh_q};
      8'h40: rdata_d = {15'b0, sil_sh_q.mode};
      8'h41: rdata_d = sil_sh_q.ur_int;
      8'h42: rdata_d = sil_sh_q.ur_phase;
      8'h43: rdata_d = sil_sh_q.cs_int;
      8'h44: rdata_d = sil_sh_q.cs_phase;
`endif
      default: ;
    endcase
`ifdef AUTD3_CTL_READBACK_EN
    for (int s = 0; s < NUM_SEGMENTS; s++) begin
      if (ADDR[7:5] == 3'b100 && ADDR[4:3] == 2'(s)) begin
        case (ADDR[2:0])
          3'd0: rdata_d = mod_sh_q[s].cycle;
          3'd1: rdata_d = mod_sh_q[s].freq_div[15:0];
          3'd2: rdata_d = mod_sh_q[s].freq_div[31:16];
          3'd3: rdata_d = mod_sh_q[s].rep[15:0];
          3'd4: rdata_d = mod_sh_q[s].rep[31:16];
          default: ;
        endcase
      end
      if (ADDR[7:5] == 3'b101 && ADDR[4:3] == 2'(s)) begin
        case (ADDR[2:0])
          3'd0: rdata_d = stm_sh_q[s].cycle;
          3'd1: rdata_d = stm_sh_q[s].freq_div[15:0];
          3'd2: rdata_d = stm_sh_q[s].freq_div[31:16];
          3'd3: rdata_d = stm_sh_q[s].rep[15:0];
          3'd4: rdata_d = stm_sh_q[s].rep[31:16];
          3'd5: rdata_d = {15'b0, stm_sh_q[s].mode};
          3'd6: rdata_d = stm_sh_q[s].sound_speed[15:0];
          default: rdata_d = stm_sh_q[s].sound_speed[31:16];
        endcase
      end
    end
`endif
  end

  // Flatten active registers onto the consumer-facing buses, segment 0 in LSBs.
  always_comb begin
    MOD_CYCLE       = '0;
    MOD_FREQ_DIV    = '0;
    MOD_REP         = '0;
    STM_CYCLE       = '0;
    STM_FREQ_DIV    = '0;
    STM_REP         = '0;
    STM_MODE        = '0;
    STM_SOUND_SPEED = '0;
    for (int s = 0; s < NUM_SEGMENTS; s++) begin
      MOD_CYCLE[16*s +: 16]       = mod_act_q[s].cycle;
      MOD_FREQ_DIV[32*s +: 32]    = mod_act_q[s].freq_div;
      MOD_REP[32*s +: 32]         = mod_act_q[s].rep;
      STM_CYCLE[16*s +: 16]       = stm_act_q[s].cycle;
      STM_FREQ_DIV[32*s +: 32]    = stm_act_q[s].freq_div;
      STM_REP[32*s +: 32]         = stm_act_q[s].rep;
      STM_MODE[s]                 = stm_act_q[s].mode;
      STM_SOUND_SPEED[32*s +: 32] = stm_act_q[s].sound_speed;
    end
    MOD_RD_SEGMENT    = mod_rd_act_q;
    STM_RD_SEGMENT    = stm_rd_act_q;
    SILENCER_MODE     = sil_act_q.mode;
    SILENCER_UR_INT   = sil_act_q.ur_int;
    SILENCER_UR_PHASE = sil_act_q.ur_phase;
    SILENCER_CS_INT   = sil_act_q.cs_int;
    SILENCER_CS_PHASE = sil_act_q.cs_phase;
  end

  // State registers with synchronous reset; silencer resets to its defaults.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the segment banks are plain flop arrays, so they take the reset
      // like any other register; a RAM-backed bank could not be cleared this way.
      for (int s = 0; s < NUM_SEGMENTS; s++) begin
        mod_sh_q[s]  <= '0;
        mod_act_q[s] <= '0;
        stm_sh_q[s]  <= '0;
        stm_act_q[s] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= IDLE;
      end
      sil_sh_q     <= SIL_RESET;
      sil_act_q    <= SIL_RESET;
      mod_rd_sh_q  <= 2'b00;
      mod_rd_act_q <= 2'b00;
      stm_rd_sh_q  <= 2'b00;
      stm_rd_act_q <= 2'b00;
      DOUT         <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // same pre-edge values, independent of statement order.
      mod_sh_q     <= mod_sh_d;
      mod_act_q    <= mod_act_d;
      stm_sh_q     <= stm_sh_d;
      stm_act_q    <= stm_act_d;
      state_q      <= state_d;
      sil_sh_q     <= sil_sh_d;
      sil_act_q    <= sil_act_d;
      mod_rd_sh_q  <= mod_rd_sh_d;
      mod_rd_act_q <= mod_rd_act_d;
      stm_rd_sh_q  <= stm_rd_sh_d;
      stm_rd_act_q <= stm_rd_act_d;
      DOUT         <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ctl_segment_latch.sv
// Self-checking bench for ctl_segment_latch: reset values, table-driven
// write/flag/ack vectors, hand-written multi-cycle corner sequences, then a
// randomized run compared against an address-indexed shadow/active model.
module tb_ctl_segment_latch;

  localparam int NS = 2;
  localparam logic [15:0] VER_MAJOR = 16'h00A2;
  localparam logic [15:0] VER_MINOR = 16'h0001;

  logic              CLK = 1'b0;
  logic              RST, WE;
  logic [7:0]        ADDR;
  logic [15:0]       DIN, DOUT;
  logic [2:0]        UPDATE_REQ, UPDATE_ACK;
  logic [16*NS-1:0]  MOD_CYCLE, STM_CYCLE;
  logic [32*NS-1:0]  MOD_FREQ_DIV, MOD_REP, STM_FREQ_DIV, STM_REP, STM_SOUND_SPEED;
  logic [NS-1:0]     STM_MODE;
  logic [1:0]        MOD_RD_SEGMENT, STM_RD_SEGMENT;
  logic              SILENCER_MODE;
  logic [15:0]       SILENCER_UR_INT, SILENCER_UR_PHASE, SILENCER_CS_INT, SILENCER_CS_PHASE;

  ctl_segment_latch #(.NUM_SEGMENTS(NS), .DATA_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT),
    .UPDATE_REQ(UPDATE_REQ), .UPDATE_ACK(UPDATE_ACK),
    .MOD_CYCLE(MOD_CYCLE), .MOD_FREQ_DIV(MOD_FREQ_DIV), .MOD_REP(MOD_REP),
    .MOD_RD_SEGMENT(MOD_RD_SEGMENT),
    .STM_CYCLE(STM_CYCLE), .STM_FREQ_DIV(STM_FREQ_DIV), .STM_REP(STM_REP),
    .STM_MODE(STM_MODE), .STM_SOUND_SPEED(STM_SOUND_SPEED),
    .STM_RD_SEGMENT(STM_RD_SEGMENT),
    .SILENCER_MODE(SILENCER_MODE), .SILENCER_UR_INT(SILENCER_UR_INT),
    .SILENCER_UR_PHASE(SILENCER_UR_PHASE), .SILENCER_CS_INT(SILENCER_CS_INT),
    .SILENCER_CS_PHASE(SILENCER_CS_PHASE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, return 1 time unit after the rising edge.
  task automatic cyc(input logic we, input logic [7:0] a, input logic [15:0] d,
                     input logic [2:0] ack);
    @(negedge CLK);
    WE = we; ADDR = a; DIN = d; UPDATE_ACK = ack;
    @(posedge CLK);
    #1;
    WE = 1'b0; UPDATE_ACK = 3'b000;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; WE = 1'b0; ADDR = 8'h00; DIN = 16'h0000; UPDATE_ACK = 3'b000;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  typedef enum {F_MOD_CYCLE, F_MOD_REP, F_MOD_RD, F_STM_CYCLE, F_STM_MODE,
                F_STM_SS, F_STM_RD, F_SIL_MODE, F_SIL_CS_INT} field_e;

  typedef struct {
    logic [7:0]   addr;
    logic [15:0]  din;
    logic [2:0]   flag;
    field_e       fld;
    logic [127:0] exp;
  } vec_t;

  function automatic logic [127:0] get_field(field_e f);
    case (f)
      F_MOD_CYCLE:  return 128'(MOD_CYCLE);
      F_MOD_REP:    return 128'(MOD_REP);
      F_MOD_RD:     return 128'(MOD_RD_SEGMENT);
      F_STM_CYCLE:  return 128'(STM_CYCLE);
      F_STM_MODE:   return 128'(STM_MODE);
      F_STM_SS:     return 128'(STM_SOUND_SPEED);
      F_STM_RD:     return 128'(STM_RD_SEGMENT);
      F_SIL_MODE:   return 128'(SILENCER_MODE);
      default:      return 128'(SILENCER_CS_INT);
    endcase
  endfunction

  // ---------------- reference model: address-indexed shadow/active memories
  logic [15:0] sh_mem  [256];
  logic [15:0] act_mem [256];
  logic [2:0]  pend;

  // Which subsystem owns a register address: 0 mod, 1 STM, 2 silencer, -1 none.
  function automatic int owner(input logic [7:0] a);
    if (a == 8'h21) return 0;
    if (a == 8'h52) return 1;
    if (a >= 8'h40 && a <= 8'h44) return 2;
    if (a[7:5] == 3'b100 && int'(a[4:3]) < NS && a[2:0] <= 3'd4) return 0;
    if (a[7:5] == 3'b101 && int'(a[4:3]) < NS) return 1;
    return -1;
  endfunction

  function automatic logic [15:0] mask_val(input logic [7:0] a, input logic [15:0] d);
    if (a == 8'h21 || a == 8'h52) return d & 16'h0003;
    if (a == 8'h40) return d & 16'h0001;
    if (a[7:5] == 3'b101 && a[2:0] == 3'd5) return d & 16'h0001;
    return d;
  endfunction

  task automatic model_init();
    for (int i = 0; i < 256; i++) begin
      sh_mem[i] = 16'h0; act_mem[i] = 16'h0;
    end
    sh_mem[8'h41] = 16'd256; sh_mem[8'h42] = 16'd256;
    sh_mem[8'h43] = 16'd10;  sh_mem[8'h44] = 16'd40;
    act_mem[8'h41] = 16'd256; act_mem[8'h42] = 16'd256;
    act_mem[8'h43] = 16'd10;  act_mem[8'h44] = 16'd40;
    pend = 3'b000;
  endtask

  function automatic logic [15:0] model_read(input logic [7:0] a);
    if (a == 8'h01) return {13'b0, pend};
    if (a == 8'h30) return VER_MAJOR;
    if (a == 8'h31) return VER_MINOR;
`ifdef AUTD3_CTL_READBACK_EN
    if (owner(a) >= 0) return sh_mem[a];
`endif
    return 16'h0;
  endfunction

  task automatic model_step(input logic we, input logic [7:0] a, input logic [15:0] d,
                            input logic [2:0] ack);
    logic [2:0] flags;
    logic [2:0] com;
    flags = 3'b000;
    if (we) begin
      if (a == 8'h00) flags = d[2:0];
      if (owner(a) >= 0) sh_mem[a] = mask_val(a, d);
    end
    com = pend & ack;
    for (int k = 0; k < 3; k++) begin
      if (com[k]) begin
        for (int i = 0; i < 256; i++) begin
          if (owner(8'(i)) == k) act_mem[i] = sh_mem[i];
        end
      end
    end
    pend = (pend & ~com) | flags;
  endtask

  task automatic compare_model(input int cycle_no);
    logic [16*NS-1:0] e_mc, e_sc;
    logic [32*NS-1:0] e_mf, e_mr, e_sf, e_sr, e_ss;
    logic [NS-1:0]    e_sm;
    for (int s = 0; s < NS; s++) begin
      e_mc[16*s +: 16] = act_mem[8'h80 + 8*s];
      e_mf[32*s +: 32] = {act_mem[8'h82 + 8*s], act_mem[8'h81 + 8*s]};
      e_mr[32*s +: 32] = {act_mem[8'h84 + 8*s], act_mem[8'h83 + 8*s]};
      e_sc[16*s +: 16] = act_mem[8'hA0 + 8*s];
      e_sf[32*s +: 32] = {act_mem[8'hA2 + 8*s], act_mem[8'hA1 + 8*s]};
      e_sr[32*s +: 32] = {act_mem[8'hA4 + 8*s], act_mem[8'hA3 + 8*s]};
      e_sm[s]          = act_mem[8'hA5 + 8*s][0];
      e_ss[32*s +: 32] = {act_mem[8'hA7 + 8*s], act_mem[8'hA6 + 8*s]};
    end
    check($sformatf("rnd%0d req", cycle_no), 128'(UPDATE_REQ), 128'(pend));
    check($sformatf("rnd%0d mod", cycle_no),
          128'({MOD_CYCLE, MOD_FREQ_DIV, MOD_REP, MOD_RD_SEGMENT}),
          128'({e_mc, e_mf, e_mr, act_mem[8'h21][1:0]}));
    check($sformatf("rnd%0d stm_a", cycle_no),
          128'({STM_CYCLE, STM_FREQ_DIV, STM_MODE, STM_RD_SEGMENT}),
          128'({e_sc, e_sf, e_sm, act_mem[8'h52][1:0]}));
    check($sformatf("rnd%0d stm_b", cycle_no),
          128'({STM_REP, STM_SOUND_SPEED}), 128'({e_sr, e_ss}));
    check($sformatf("rnd%0d sil", cycle_no),
          128'({SILENCER_MODE, SILENCER_UR_INT, SILENCER_UR_PHASE,
                SILENCER_CS_INT, SILENCER_CS_PHASE}),
          128'({act_mem[8'h40][0], act_mem[8'h41], act_mem[8'h42],
                act_mem[8'h43], act_mem[8'h44]}));
  endtask

  vec_t vt [13];

  initial begin
    logic [15:0] exp_rb;
    logic [7:0]  ra;
    logic [15:0] rd;
    logic        rw;
    logic [2:0]  rack;
    logic [15:0] exp_dout;

    RST = 1'b0; WE = 1'b0; ADDR = 8'h00; DIN = 16'h0000; UPDATE_ACK = 3'b000;

    // ---------------- reset values
    do_reset();
    check("rst req", 128'(UPDATE_REQ), 128'(3'b000));
    check("rst mod", 128'({MOD_CYCLE, MOD_FREQ_DIV, MOD_REP, MOD_RD_SEGMENT}), 128'(0));
    check("rst stm", 128'({STM_CYCLE, STM_FREQ_DIV, STM_MODE, STM_RD_SEGMENT}), 128'(0));
    check("rst stm2", 128'({STM_REP, STM_SOUND_SPEED}), 128'(0));
    check("rst sil_mode", 128'(SILENCER_MODE), 128'(1'b0));
    check("rst cs_int", 128'(SILENCER_CS_INT), 128'(16'd10));
    check("rst cs_phase", 128'(SILENCER_CS_PHASE), 128'(16'd40));
    check("rst ur", 128'({SILENCER_UR_INT, SILENCER_UR_PHASE}), 128'({16'd256, 16'd256}));
    check("rst dout", 128'(DOUT), 128'(16'h0));

    // ---------------- atomic mod commit
    cyc(1'b1, 8'h81, 16'h5000, 3'b000);
    cyc(1'b1, 8'h82, 16'h0001, 3'b000);
    check("mod hold after shadow write", 128'(MOD_FREQ_DIV[31:0]), 128'(32'h0));
    cyc(1'b1, 8'h00, 16'h0001, 3'b000);
    check("mod req rise", 128'(UPDATE_REQ), 128'(3'b001));
    check("mod hold pending", 128'(MOD_FREQ_DIV[31:0]), 128'(32'h0));
    cyc(1'b0, 8'h00, 16'h0000, 3'b000);
    cyc(1'b0, 8'h00, 16'h0000, 3'b000);
    check("mod hold idle cycles", 128'(MOD_FREQ_DIV[31:0]), 128'(32'h0));
    check("mod req held", 128'(UPDATE_REQ), 128'(3'b001));
    cyc(1'b0, 8'h00, 16'h0000, 3'b001);
    check("mod commit fdiv", 128'(MOD_FREQ_DIV[31:0]), 128'(32'h00015000));
    check("mod commit req clear", 128'(UPDATE_REQ), 128'(3'b000));

    // ---------------- table: write, flag, ack, compare one active field
    vt[0]  = '{8'h8B, 16'h1234, 3'b001, F_MOD_REP,    128'(64'h00001234_00000000)};
    vt[1]  = '{8'h80, 16'hBEEF, 3'b001, F_MOD_CYCLE,  128'(32'h0000BEEF)};
    vt[2]  = '{8'h85, 16'hFFFF, 3'b001, F_MOD_CYCLE,  128'(32'h0000BEEF)};
    vt[3]  = '{8'h98, 16'h1111, 3'b001, F_MOD_CYCLE,  128'(32'h0000BEEF)};
    vt[4]  = '{8'h21, 16'h0003, 3'b001, F_MOD_RD,     128'(2'd3)};
    vt[5]  = '{8'hA8, 16'd100,  3'b010, F_STM_CYCLE,  128'(32'h0064_0000)};
    vt[6]  = '{8'hAD, 16'h0001, 3'b010, F_STM_MODE,   128'(2'b10)};
    vt[7]  = '{8'hB0, 16'h7777, 3'b010, F_STM_CYCLE,  128'(32'h0064_0000)};
    vt[8]  = '{8'hA7, 16'h00AB, 3'b010, F_STM_SS,     128'(64'h00000000_00AB0000)};
    vt[9]  = '{8'h52, 16'h0002, 3'b010, F_STM_RD,     128'(2'd2)};
    vt[10] = '{8'h43, 16'h0007, 3'b100, F_SIL_CS_INT, 128'(16'd7)};
    vt[11] = '{8'h40, 16'h0001, 3'b100, F_SIL_MODE,   128'(1'b1)};
    vt[12] = '{8'h45, 16'h0033, 3'b100, F_SIL_CS_INT, 128'(16'd7)};
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, vt[i].addr, vt[i].din, 3'b000);
      cyc(1'b1, 8'h00, {13'b0, vt[i].flag}, 3'b000);
      check($sformatf("vec%0d req", i), 128'(UPDATE_REQ), 128'(vt[i].flag));
      cyc(1'b0, 8'h00, 16'h0000, vt[i].flag);
      check($sformatf("vec%0d %s", i, vt[i].fld.name()), get_field(vt[i].fld), vt[i].exp);
      check($sformatf("vec%0d req clear", i), 128'(UPDATE_REQ), 128'(3'b000));
    end

    // ---------------- rewrite while pending uses the latest shadow
    cyc(1'b1, 8'h00, 16'h0004, 3'b000);
    cyc(1'b1, 8'h43, 16'd20, 3'b000);
    check("rewrite hold", 128'(SILENCER_CS_INT), 128'(16'd7));
    cyc(1'b0, 8'h00, 16'h0000, 3'b100);
    check("rewrite cs_int", 128'(SILENCER_CS_INT), 128'(16'd20));

    // ---------------- flag write coincident with ack
    cyc(1'b1, 8'h44, 16'h0055, 3'b000);
    cyc(1'b1, 8'h00, 16'h0004, 3'b000);
    cyc(1'b1, 8'h00, 16'h0004, 3'b100);
    check("coincident commit", 128'(SILENCER_CS_PHASE), 128'(16'h0055));
    check("coincident req kept", 128'(UPDATE_REQ), 128'(3'b100));

    // ---------------- shadow write in the ack cycle is included (write-first)
    cyc(1'b1, 8'h42, 16'h0099, 3'b100);
    check("write-first ur_phase", 128'(SILENCER_UR_PHASE), 128'(16'h0099));
    check("write-first req clear", 128'(UPDATE_REQ), 128'(3'b000));

    // ---------------- ack while idle is ignored
    cyc(1'b1, 8'h80, 16'h1234, 3'b000);
    cyc(1'b0, 8'h00, 16'h0000, 3'b111);
    check("idle ack ignored", 128'(MOD_CYCLE), 128'(32'h0000BEEF));
    check("idle ack req", 128'(UPDATE_REQ), 128'(3'b000));

    // ---------------- reset while pending drops the request
    cyc(1'b1, 8'h80, 16'h4444, 3'b000);
    cyc(1'b1, 8'h00, 16'h0001, 3'b000);
    check("pre-reset req", 128'(UPDATE_REQ), 128'(3'b001));
    do_reset();
    cyc(1'b0, 8'h00, 16'h0000, 3'b001);
    check("reset pend mod", 128'({MOD_CYCLE, MOD_FREQ_DIV, MOD_REP}), 128'(0));
    check("reset pend req", 128'(UPDATE_REQ), 128'(3'b000));
    check("reset pend cs_int", 128'(SILENCER_CS_INT), 128'(16'd10));

    // ---------------- readback
`ifdef AUTD3_CTL_READBACK_EN
    exp_rb = 16'h5000;
`else
    exp_rb = 16'h0000;
`endif
    cyc(1'b1, 8'h81, 16'h5000, 3'b000);
    cyc(1'b0, 8'h81, 16'h0000, 3'b000);
    check("readback 0x81", 128'(DOUT), 128'(exp_rb));
    cyc(1'b1, 8'h00, 16'h0003, 3'b000);
    cyc(1'b0, 8'h01, 16'h0000, 3'b000);
    check("readback pending", 128'(DOUT), 128'(16'h0003));
    cyc(1'b0, 8'h30, 16'h0000, 3'b000);
    check("version major", 128'(DOUT), 128'(VER_MAJOR));
    cyc(1'b0, 8'h31, 16'h0000, 3'b000);
    check("version minor", 128'(DOUT), 128'(VER_MINOR));

    // ---------------- randomized run against the model
    do_reset();
    model_init();
    for (int n = 0; n < 3000; n++) begin
      rw = 1'b0;
      rd = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 8'($urandom);
        1: begin ra = 8'h80 + 8'($urandom_range(0, 31)); rw = 1'b1; end
        2: begin ra = 8'hA0 + 8'($urandom_range(0, 31)); rw = 1'b1; end
        3: begin ra = 8'h40 + 8'($urandom_range(0, 5));  rw = 1'b1; end
        4: begin ra = ($urandom_range(0, 1) == 0) ? 8'h21 : 8'h52; rw = 1'b1; end
        5: begin ra = 8'h00; rw = 1'b1; end
        6: ra = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h30;
        default: begin ra = 8'($urandom); rw = ($urandom_range(0, 1) == 0); end
      endcase
      for (int k = 0; k < 3; k++) rack[k] = ($urandom_range(0, 2) == 0);
      @(negedge CLK);
      WE = rw; ADDR = ra; DIN = rd; UPDATE_ACK = rack;
      exp_dout = model_read(ra);
      model_step(rw, ra, rd, rack);
      @(posedge CLK);
      #1;
      compare_model(n);
      check($sformatf("rnd%0d dout", n), 128'(DOUT), 128'(exp_dout));
    end
    WE = 1'b0; UPDATE_ACK = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
